// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio source generators: FSM states and
// elaboration-time helpers for clock-derived counter sizing.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } toneState_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Counter width for a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned msCycles(input int unsigned clkHz);
    return clkHz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every MS_CYC clocks, held at zero while clr is high.
module ms_tick_gen #(
  parameter int unsigned MS_CYC = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);
  import audio_pkg::*;

  localparam int unsigned PRE_W = cntWidth(MS_CYC);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(MS_CYC - 1);

  logic [PRE_W-1:0] preCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preCnt <= '0;
    end else if (clr || (preCnt == LAST)) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + PRE_W'(1);
    end
  end

  assign tick_c = !clr && (preCnt == LAST);

endmodule

// File: rtl/tone_pwm_gen.sv
// Square-wave tone source for the audio mux: plays one latched note request,
// then a fixed silent gap, reporting busy/done for a melody sequencer.
module tone_pwm_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned PERIOD_W = 20,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned GAP_MS   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [LEN_W-1:0]    note_ms,
  output logic                busy,
  output logic                done,
  output logic                pwm_out,
  output logic                audio_en
);
  import audio_pkg::*;

  localparam int unsigned MS_CYC  = msCycles(CLK_HZ);
  localparam int unsigned GAP_W   = cntWidth(GAP_MS + 1);
  localparam bit          HAS_GAP = (GAP_MS != 0);

  toneState_t          state, stateNext;
  logic [PERIOD_W-1:0] hpReg, hpNext;
  logic [PERIOD_W-1:0] toneCnt, toneCntNext;
  logic [LEN_W-1:0]    remMs, remMsNext;
  logic [GAP_W-1:0]    gapCnt, gapCntNext;
  logic                busyNext, doneNext, pwmNext, audioNext;
  logic                tick_c;
  logic                preClr_c;

  // The prescaler idles at zero, so every PLAY and GAP phase starts on a fresh ms.
  assign preClr_c = (state == IDLE);

  ms_tick_gen #(
    .MS_CYC(MS_CYC)
  ) u_msTick (
    .clk   (clk),
    .rst   (rst),
    .clr   (preClr_c),
    .tick_c(tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hpReg    <= '0;
      toneCnt  <= '0;
      remMs    <= '0;
      gapCnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pwm_out  <= 1'b0;
      audio_en <= 1'b0;
    end else begin
      state    <= stateNext;
      hpReg    <= hpNext;
      toneCnt  <= toneCntNext;
      remMs    <= remMsNext;
      gapCnt   <= gapCntNext;
      busy     <= busyNext;
      done     <= doneNext;
      pwm_out  <= pwmNext;
      audio_en <= audioNext;
    end
  end

  always_comb begin
    stateNext   = state;
    hpNext      = hpReg;
    toneCntNext = toneCnt;
    remMsNext   = remMs;
    gapCntNext  = gapCnt;
    busyNext    = busy;
    doneNext    = 1'b0;
    pwmNext     = pwm_out;
    audioNext   = audio_en;

    case (state)
      IDLE: begin
        toneCntNext = '0;
        // The done cycle is still part of the previous note, so requests there are dropped.
        if (start && (note_ms != '0) && !done) begin
          stateNext = PLAY;
          hpNext    = half_period;
          remMsNext = note_ms;
          busyNext  = 1'b1;
          pwmNext   = 1'b0;
          audioNext = (half_period != '0);
        end
      end

      PLAY: begin
        if (hpReg != '0) begin
          if (toneCnt == hpReg - PERIOD_W'(1)) begin
            toneCntNext = '0;
            pwmNext     = !pwm_out;
          end else begin
            toneCntNext = toneCnt + PERIOD_W'(1);
          end
        end
        if (tick_c) begin
          remMsNext = remMs - LEN_W'(1);
          if (remMs == LEN_W'(1)) begin
            toneCntNext = '0;
            pwmNext     = 1'b0;
            audioNext   = 1'b0;
            if (HAS_GAP) begin
              stateNext  = GAP;
              gapCntNext = GAP_W'(GAP_MS);
            end else begin
              stateNext = IDLE;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
            end
          end
        end
      end

      GAP: begin
        toneCntNext = '0;
        if (tick_c) begin
          gapCntNext = gapCnt - GAP_W'(1);
          if (gapCnt == GAP_W'(1)) begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
        pwmNext   = 1'b0;
        audioNext = 1'b0;
      end
    endcase
  end

endmodule
